// File: rtl/spi_pkg.sv
// Shared SPI definitions: command encoding of the 10-bit rx word and
// the widths used by the slave, the command RAM and the wrapper bench.
package spi_pkg;

    localparam int CMD_W  = 2;
    localparam int DATA_W = 8;
    localparam int RX_W   = 10;

    typedef enum logic [CMD_W-1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    // Command field of an rx word.
    function automatic cmd_e rx_cmd(input logic [RX_W-1:0] word);
        return cmd_e'(word[RX_W-1:DATA_W]);
    endfunction

endpackage

// File: rtl/spi_ram_cmd_if.sv
// Link between the SPI slave (master side) and the command RAM (slave side):
// rx command word in, read byte and status out.
interface spi_ram_cmd_if;
    import spi_pkg::*;

    logic [RX_W-1:0]   din;
    logic              rx_valid;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              cmd_err;

    modport master (
        output din,
        output rx_valid,
        input  dout,
        input  tx_valid,
        input  cmd_err
    );

    modport slave (
        input  din,
        input  rx_valid,
        output dout,
        output tx_valid,
        output cmd_err
    );

endinterface

// File: rtl/spi_ram_array.sv
// MEM_DEPTH x 8 single-port storage with synchronous write and a registered
// read port. The read register is cleared by reset; the array itself is not.
module spi_ram_array
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    // Storage write; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds its byte until the next read.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    // Read register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_cmd.sv
// Command-decoding RAM behind the SPI slave. Each accepted rx word either
// latches a write/read address, writes a byte, or reads a byte back for MISO.
// Writes/reads issued without a preceding address command raise cmd_err for
// one cycle but are still carried out.
module spi_ram_cmd
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_ram_cmd_if.slave  bus
);

    logic [ADDR_SIZE-1:0] wr_addr_d, wr_addr_q;
    logic [ADDR_SIZE-1:0] rd_addr_d, rd_addr_q;
    logic                 wr_addr_vld_d, wr_addr_vld_q;
    logic                 rd_addr_vld_d, rd_addr_vld_q;
    logic                 tx_valid_d, tx_valid_q;
    logic                 cmd_err_d, cmd_err_q;
    logic                 mem_we;
    logic                 mem_re;

    // Decode one accepted command into next-state and RAM strobes.
    always_comb begin
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
        wr_addr_vld_d = wr_addr_vld_q;
        rd_addr_vld_d = rd_addr_vld_q;
        tx_valid_d    = tx_valid_q;
        cmd_err_d     = 1'b0;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        if (bus.rx_valid) begin
            unique case (rx_cmd(bus.din))
                CMD_WR_ADDR: begin
                    wr_addr_d     = bus.din[ADDR_SIZE-1:0];
                    wr_addr_vld_d = 1'b1;
                    tx_valid_d    = 1'b0;
                end
                CMD_WR_DATA: begin
                    mem_we     = 1'b1;
                    tx_valid_d = 1'b0;
                    cmd_err_d  = !wr_addr_vld_q;
                end
                CMD_RD_ADDR: begin
                    rd_addr_d     = bus.din[ADDR_SIZE-1:0];
                    rd_addr_vld_d = 1'b1;
                    tx_valid_d    = 1'b0;
                end
                CMD_RD_DATA: begin
                    mem_re        = 1'b1;
                    tx_valid_d    = 1'b1;
                    rd_addr_vld_d = 1'b0;
                    cmd_err_d     = !rd_addr_vld_q;
                end
            endcase
        end
    end

    // Control registers; reset wins over a simultaneous command.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            wr_addr_vld_q <= 1'b0;
            rd_addr_vld_q <= 1'b0;
            tx_valid_q    <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            wr_addr_vld_q <= wr_addr_vld_d;
            rd_addr_vld_q <= rd_addr_vld_d;
            tx_valid_q    <= tx_valid_d;
            cmd_err_q     <= cmd_err_d;
        end
    end

    spi_ram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we && rst_n),
        .waddr (wr_addr_q),
        .wdata (bus.din[DATA_W-1:0]),
        .re    (mem_re),
        .raddr (rd_addr_q),
        .rdata (bus.dout)
    );

    assign bus.tx_valid = tx_valid_q;
    assign bus.cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_cmd.sv
// Directed bench for spi_ram_cmd: two builds (ADDR_SIZE 8 and 4) checked
// every cycle against a command-level model, plus literal spot checks.
module tb_spi_ram_cmd;

    logic clk = 1'b0;
    logic rst_n0;
    logic rst_n1;

    spi_ram_cmd_if if0 ();
    spi_ram_cmd_if if1 ();

    spi_ram_cmd #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut0 (
        .clk   (clk),
        .rst_n (rst_n0),
        .bus   (if0)
    );

    spi_ram_cmd #(.MEM_DEPTH(16), .ADDR_SIZE(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n1),
        .bus   (if1)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Command-level model state, one set per build.
    logic [7:0] m_mem   [2][256];
    bit         m_known [2][256];
    logic [7:0] m_wa    [2];
    logic [7:0] m_ra    [2];
    bit         m_wv    [2];
    bit         m_rv    [2];
    logic [7:0] m_dout  [2];
    bit         m_dknown[2];
    bit         m_tx    [2];
    bit         m_err   [2];
    bit         m_live  [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] get_dout(input int k);
        return (k == 0) ? if0.dout : if1.dout;
    endfunction

    function automatic logic get_tx(input int k);
        return (k == 0) ? if0.tx_valid : if1.tx_valid;
    endfunction

    function automatic logic get_err(input int k);
        return (k == 0) ? if0.cmd_err : if1.cmd_err;
    endfunction

    // Apply the command rules to the model for one clock edge.
    task automatic model(input int k, input bit r, input bit v, input logic [9:0] d);
        logic [7:0] mask;
        mask = (k == 0) ? 8'hFF : 8'h0F;
        if (!r) begin
            m_dout[k] = 8'h00; m_dknown[k] = 1'b1;
            m_tx[k] = 1'b0; m_err[k] = 1'b0;
            m_wa[k] = 8'h00; m_ra[k] = 8'h00;
            m_wv[k] = 1'b0; m_rv[k] = 1'b0;
            m_live[k] = 1'b1;
        end else if (!v) begin
            m_err[k] = 1'b0;
        end else begin
            m_err[k] = 1'b0;
            case (d[9:8])
                2'b00: begin m_wa[k] = d[7:0] & mask; m_wv[k] = 1'b1; m_tx[k] = 1'b0; end
                2'b01: begin
                    m_mem[k][m_wa[k]] = d[7:0];
                    m_known[k][m_wa[k]] = 1'b1;
                    m_tx[k] = 1'b0;
                    m_err[k] = !m_wv[k];
                end
                2'b10: begin m_ra[k] = d[7:0] & mask; m_rv[k] = 1'b1; m_tx[k] = 1'b0; end
                default: begin
                    m_dout[k] = m_mem[k][m_ra[k]];
                    m_dknown[k] = m_known[k][m_ra[k]];
                    m_tx[k] = 1'b1;
                    m_err[k] = !m_rv[k];
                    m_rv[k] = 1'b0;
                end
            endcase
        end
    endtask

    // One clock: drive build k (the other idles), update model, return at negedge.
    task automatic cmd(input int k, input bit r, input bit v, input logic [9:0] d);
        rst_n0 = 1'b1; if0.rx_valid = 1'b0; if0.din = 10'h000;
        rst_n1 = 1'b1; if1.rx_valid = 1'b0; if1.din = 10'h000;
        if (k == 0) begin rst_n0 = r; if0.rx_valid = v; if0.din = d; end
        else        begin rst_n1 = r; if1.rx_valid = v; if1.din = d; end
        @(posedge clk);
        model(k, r, v, d);
        model(1 - k, 1'b1, 1'b0, 10'h000);
        @(negedge clk);
    endtask

    task automatic send(input int k, input logic [9:0] d);
        cmd(k, 1'b1, 1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cmd(0, 1'b1, 1'b0, 10'h000);
    endtask

    // Per-cycle comparison of both builds against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (m_live[k]) begin
                chk($sformatf("dut%0d tx_valid", k), 32'(get_tx(k)), 32'(m_tx[k]));
                chk($sformatf("dut%0d cmd_err", k), 32'(get_err(k)), 32'(m_err[k]));
                if (m_dknown[k])
                    chk($sformatf("dut%0d dout", k), 32'(get_dout(k)), 32'(m_dout[k]));
            end
        end
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_live[k] = 1'b0;
            for (int a = 0; a < 256; a++) m_known[k][a] = 1'b0;
        end

        // Reset both builds with a command held on the bus.
        rst_n0 = 1'b0; if0.rx_valid = 1'b1; if0.din = 10'h0FF;
        rst_n1 = 1'b0; if1.rx_valid = 1'b1; if1.din = 10'h0FF;
        repeat (2) begin
            @(posedge clk);
            model(0, 1'b0, 1'b1, 10'h0FF);
            model(1, 1'b0, 1'b1, 10'h0FF);
        end
        @(negedge clk);
        chk("reset dout", 32'(if0.dout), 32'h0);
        chk("reset tx_valid", 32'(if0.tx_valid), 32'h0);
        chk("reset cmd_err", 32'(if0.cmd_err), 32'h0);

        // No address latched by reset: WR_DATA errs and writes mem[0]=11.
        send(0, {2'b01, 8'h11});
        chk("wr no addr err", 32'(if0.cmd_err), 32'h1);
        idle(1);

        // Reset, then RD_DATA with no read address: reads mem[0].
        cmd(0, 1'b0, 1'b0, 10'h000);
        send(0, {2'b11, 8'h00});
        chk("order dout", 32'(if0.dout), 32'h11);
        chk("order tx_valid", 32'(if0.tx_valid), 32'h1);
        chk("order cmd_err", 32'(if0.cmd_err), 32'h1);
        idle(1);
        chk("order err one cycle", 32'(if0.cmd_err), 32'h0);

        // Write path and held tx_valid.
        send(0, {2'b00, 8'h3C});
        send(0, {2'b01, 8'hA5});
        send(0, {2'b10, 8'h3C});
        send(0, {2'b11, 8'h00});
        chk("wpath dout", 32'(if0.dout), 32'hA5);
        chk("wpath tx_valid", 32'(if0.tx_valid), 32'h1);
        idle(5);
        chk("wpath held tx", 32'(if0.tx_valid), 32'h1);
        chk("wpath held dout", 32'(if0.dout), 32'hA5);

        // Double RD_DATA.
        send(0, {2'b00, 8'h07});
        send(0, {2'b01, 8'hC3});
        send(0, {2'b10, 8'h07});
        send(0, {2'b11, 8'h00});
        chk("rd1 err", 32'(if0.cmd_err), 32'h0);
        send(0, {2'b11, 8'hFF});
        chk("rd2 dout", 32'(if0.dout), 32'hC3);
        chk("rd2 err", 32'(if0.cmd_err), 32'h1);
        send(0, {2'b00, 8'h55});
        chk("wr_addr drops tx", 32'(if0.tx_valid), 32'h0);

        // Mid-sequence reset.
        send(0, {2'b00, 8'h20});
        send(0, {2'b01, 8'h77});
        send(0, {2'b00, 8'h20});
        cmd(0, 1'b0, 1'b0, 10'h000);
        send(0, {2'b01, 8'h5A});
        chk("midrst err", 32'(if0.cmd_err), 32'h1);
        send(0, {2'b10, 8'h00});
        send(0, {2'b11, 8'h00});
        chk("midrst addr0", 32'(if0.dout), 32'h5A);
        send(0, {2'b10, 8'h20});
        send(0, {2'b11, 8'h00});
        chk("midrst addr20", 32'(if0.dout), 32'h77);

        // Write then read back on consecutive commands, new address.
        send(0, {2'b00, 8'hFF});
        send(0, {2'b10, 8'hFF});
        send(0, {2'b01, 8'h3E});
        send(0, {2'b11, 8'h00});
        chk("wr-rd same addr", 32'(if0.dout), 32'h3E);

        // ADDR_SIZE=4 build: upper nibble ignored.
        send(1, {2'b00, 8'hF3});
        send(1, {2'b01, 8'h99});
        send(1, {2'b10, 8'h03});
        send(1, {2'b11, 8'h5C});
        chk("a4 dout", 32'(if1.dout), 32'h99);
        chk("a4 tx_valid", 32'(if1.tx_valid), 32'h1);
        send(1, {2'b10, 8'hA3});
        send(1, {2'b11, 8'h00});
        chk("a4 alias dout", 32'(if1.dout), 32'h99);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
